// File: rtl/binary_gcd_engine.sv
// Multi-cycle binary (Stein) GCD engine: SHIFT strips common factors of two,
// REDUCE runs halving/subtract steps, DONE pulses done for one clock.
// Ports: clk, rst_n (sync, active-low), start/a/b request; busy, done,
// gcd, zero_err and cycles (SHIFT+REDUCE clocks) results held until next start.
module binary_gcd_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd,
    output logic             zero_err,
    output logic [CNT_W-1:0] cycles
);
    localparam int KW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        REDUCE,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [KW-1:0]    k;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] a_minus_b;
    logic [WIDTH-1:0] b_minus_a;

    // Saturating increment; the counter never wraps.
    always_comb begin
        cnt_inc = cnt;
        if (cnt != '1) begin
            cnt_inc = cnt + 1'b1;
        end
    end

    // Only the difference selected by the a_r > b_r compare is used,
    // so the chosen subtraction never borrows.
    always_comb begin
        a_minus_b = a_r - b_r;
        b_minus_a = b_r - a_r;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            k        <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            gcd      <= '0;
            zero_err <= 1'b0;
            cycles   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        k      <= '0;
                        cnt    <= '0;
                        cycles <= '0;
                        busy   <= 1'b1;
                        if (a == '0 || b == '0) begin
                            // gcd(x,0)=x; both zero is flagged.
                            state    <= DONE;
                            done     <= 1'b1;
                            gcd      <= a | b;
                            zero_err <= (a == '0) && (b == '0);
                        end else begin
                            state    <= SHIFT;
                            gcd      <= '0;
                            zero_err <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    cnt <= cnt_inc;
                    if (!a_r[0] && !b_r[0]) begin
                        a_r <= a_r >> 1;
                        b_r <= b_r >> 1;
                        k   <= k + 1'b1;
                    end else begin
                        state <= REDUCE;
                    end
                end
                REDUCE: begin
                    cnt <= cnt_inc;
                    if (a_r == b_r) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        // k counts only shared factors, so the shift
                        // restores them without dropping set bits.
                        gcd      <= a_r << k;
                        cycles   <= cnt_inc;
                        zero_err <= (a_r == '0) && (b_r == '0);
                    end else if (!a_r[0]) begin
                        a_r <= a_r >> 1;
                    end else if (!b_r[0]) begin
                        b_r <= b_r >> 1;
                    end else if (a_r > b_r) begin
                        a_r <= a_minus_b >> 1;
                    end else begin
                        b_r <= b_minus_a >> 1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/binary_gcd_engine.md
BINARY_GCD_ENGINE -- requirements
Module: binary_gcd_engine

Interface
REQ-001 The block SHALL use parameter WIDTH, default 16, as the operand and result width in bits (legal range 4..64).
REQ-002 The block SHALL use parameter CNT_W, default 8, as the width of the iteration counter output.
REQ-003 The block SHALL provide port clk, input, 1 bit: clock, all state updated on rising edge.
REQ-004 The block SHALL provide port rst_n, input, 1 bit: reset, synchronous, active-low; clock clk.
REQ-005 The block SHALL provide port start, input, 1 bit: request, sampled only in IDLE.
REQ-006 The block SHALL provide ports a and b, input, WIDTH bits each: unsigned operands, captured on an accepted start.
REQ-007 The block SHALL provide port busy, output, 1 bit: high in every state except IDLE.
REQ-008 The block SHALL provide port done, output, 1 bit: single-cycle completion pulse.
REQ-009 The block SHALL provide port gcd, output, WIDTH bits: result, held from the done cycle until the next accepted start.
REQ-010 The block SHALL provide port zero_err, output, 1 bit: set with done when both operands are 0, held like gcd.
REQ-011 The block SHALL provide port cycles, output, CNT_W bits: clocks spent in SHIFT plus REDUCE for the last operation, held like gcd.

Function
REQ-012 The block SHALL implement states IDLE, SHIFT, REDUCE and DONE, with internal registers A, B (WIDTH bits), k ($clog2(WIDTH+1) bits) and an iteration counter.
REQ-013 IDLE, start=1: the block SHALL load A=a, B=b, k=0 and counter=0, and clear gcd, zero_err and cycles.
REQ-014 From IDLE with an accepted start, the next state SHALL be DONE if a==0 or b==0, else SHIFT; start=0 SHALL keep the block in IDLE.
REQ-015 SHIFT, A and B both even: the block SHALL set A>>=1, B>>=1, k+=1 and stay in SHIFT.
REQ-016 SHIFT, A or B odd: the block SHALL go to REDUCE with A, B and k unchanged.
REQ-017 REDUCE: the block SHALL apply the first matching rule per cycle:
- A==B: go to DONE.
- A even: A>>=1.
- B even: B>>=1.
- A>B: A=(A-B)>>1.
- otherwise: B=(B-A)>>1.
REQ-018 In every SHIFT or REDUCE cycle the counter SHALL increment, saturating at 2^CNT_W-1 with no wrap.
REQ-019 Subtractions SHALL be unsigned WIDTH-bit operations, always performed with larger minus smaller so no borrow occurs.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 On entry to DONE, gcd SHALL be set as follows:
- nonzero path: gcd = A<<k, truncated to WIDTH bits (never loses set bits).
- zero path: gcd = A|B.
REQ-022 On entry to DONE, cycles SHALL equal the counter value and zero_err SHALL equal (A==0 && B==0).
REQ-023 start SHALL be ignored while busy=1, including during DONE, and a, b SHALL not be sampled after the accept cycle.
REQ-024 Latency SHALL be cycles+1 clocks from the accepting edge to the done pulse, and cycles SHALL not exceed 3*WIDTH+1.
REQ-025 start held high continuously SHALL start a new operation on the first IDLE cycle after each done.

Reset
REQ-026 With rst_n=0 at a clock edge, the block SHALL enter IDLE and clear A, B, k, the counter, gcd, cycles, done, busy and zero_err to 0.
REQ-027 A reset during SHIFT, REDUCE or DONE SHALL abort the operation with no done pulse, and start on the first edge with rst_n=1 SHALL be accepted normally.

Verification
REQ-028 The bench SHALL cover: a=48, b=18, start pulse -> done 8 edges after accept, gcd=6, cycles=7, zero_err=0.
REQ-029 The bench SHALL cover: a=0, b=20 -> done 1 edge after accept, gcd=20, cycles=0; then a=0, b=0 -> gcd=0, zero_err=1.
REQ-030 The bench SHALL cover: a=b=0x8000 with WIDTH=16 -> gcd=0x8000 with no overflow; and a=0xFFFF, b=1 -> gcd=1, cycles not exceeding 49.
REQ-031 The bench SHALL cover: start re-pulsed with new a, b while busy -> ignored, and the result still belongs to the first operands.
REQ-032 The bench SHALL cover: rst_n=0 in the middle of REDUCE -> no done, all outputs 0; then a=35, b=21 -> gcd=7.
REQ-033 The bench SHALL cover: a 500-pair random sweep at WIDTH=8 and WIDTH=32, checking gcd against a reference model and that each done is exactly one cycle wide.
